mux_arbiter: RTL

//  Two-requester valid/ready arbiter sequencing the 16-bit 3-to-1 select mux (00->b, 01->a, else 0).

---
 rtl/mux_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester valid/ready arbiter that drives the select of a
// 16-bit 3-to-1 mux (00 -> b, 01 -> a, else 0) and registers the muxed word.
// Round-robin between A and B, with a burst hold of MAX_BURST beats.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   a_data/a_valid/a_ready   source A stream
//   b_data/b_valid/b_ready   source B stream
//   out_data/out_valid/out_ready  registered output stream (data 0 when not valid)
//   sel_o                current mux select: IDLE=10, GRANT_A=01, GRANT_B=00
// Optional (MUX_ARB_STATS_EN defined):
//   stats_clr            synchronous clear of the beat counters
//   a_beats, b_beats     saturating accepted-beat counters per source

module mux_arbiter_mux #(
  parameter int unsigned N = 16
) (
  input  logic [1:0]   sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  always_comb begin
    case (sel)
      2'b00:   y = b;
      2'b01:   y = a;
      default: y = '0;
    endcase
  end
endmodule

module mux_arbiter #(
  parameter int unsigned N         = 16,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [N-1:0]     b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MUX_ARB_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] a_beats,
  output logic [CNT_W-1:0] b_beats,
`endif
  output logic [1:0]       sel_o
);

  localparam int unsigned BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

  // State encoding equals the mux select so sel_o is a direct register output.
  typedef enum logic [1:0] {
    GRANT_B = 2'b00,
    GRANT_A = 2'b01,
    IDLE    = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
  logic           last_b_q, last_b_d;   // 1: B was the last source served
  logic [N-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;

  logic           load_en;
  logic           accept_a, accept_b;
  logic [N-1:0]   mux_y;
  logic [BW-1:0]  burst_inc;
  logic           burst_done;

  mux_arbiter_mux #(.N(N)) u_mux (
    .sel (state_q),
    .a   (a_data),
    .b   (b_data),
    .y   (mux_y)
  );

  assign load_en    = !out_valid_q || out_ready;
  assign a_ready    = (state_q == GRANT_A) && load_en;
  assign b_ready    = (state_q == GRANT_B) && load_en;
  assign accept_a   = a_valid && a_ready;
  assign accept_b   = b_valid && b_ready;
  assign burst_inc  = burst_cnt_q + BW'(1);
  assign burst_done = (burst_inc == BW'(MAX_BURST));

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_b_d    = last_b_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (accept_a || accept_b) begin
      out_data_d  = mux_y;
      out_valid_d = 1'b1;
      burst_cnt_d = burst_inc;
      last_b_d    = accept_b;
    end else if (load_en) begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (a_valid && b_valid)
          state_d = last_b_q ? GRANT_A : GRANT_B;
        else if (a_valid)
          state_d = GRANT_A;
        else if (b_valid)
          state_d = GRANT_B;
      end
      GRANT_A: begin
        if (accept_a && burst_done) begin
          burst_cnt_d = '0;
          if (b_valid) state_d = GRANT_B;
        end else if (!a_valid) begin
          burst_cnt_d = '0;
          state_d     = b_valid ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        if (accept_b && burst_done) begin
          burst_cnt_d = '0;
          if (a_valid) state_d = GRANT_A;
        end else if (!b_valid) begin
          burst_cnt_d = '0;
          state_d     = a_valid ? GRANT_A : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_b_q    <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_b_q    <= last_b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_o     = state_q;

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] a_beats_q, a_beats_d;
  logic [CNT_W-1:0] b_beats_q, b_beats_d;

  always_comb begin
    a_beats_d = a_beats_q;
    b_beats_d = b_beats_q;
    if (stats_clr) begin
      a_beats_d = '0;
      b_beats_d = '0;
    end else begin
      if (accept_a && (a_beats_q != '1)) a_beats_d = a_beats_q + CNT_W'(1);
      if (accept_b && (b_beats_q != '1)) b_beats_d = b_beats_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_beats_q <= '0;
      b_beats_q <= '0;
    end else begin
      a_beats_q <= a_beats_d;
      b_beats_q <= b_beats_d;
    end
  end

  assign a_beats = a_beats_q;
  assign b_beats = b_beats_q;
`endif

endmodule
